// File: rtl/hsst_sched_pkg.sv
// Shared types and constants for the HSST TX lane burst scheduler.
// Holds the link word encodings and the scheduler FSM state type.
package hsst_sched_pkg;

  localparam logic [23:0] IDLE_WORD = 24'h00_0000;
  localparam logic [7:0]  HDR_TAG   = 8'hC3;
  localparam logic [7:0]  HDR_LOW   = 8'hFF;
  localparam int          VALID_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  // Burst header: tag byte, source id in the middle byte, valid flag set in the low byte.
  function automatic logic [23:0] make_hdr(input logic [2:0] id);
    return {HDR_TAG, 5'b0_0000, id, HDR_LOW};
  endfunction

  // Pixel words travel with the link valid flag forced on.
  function automatic logic [23:0] force_valid(input logic [23:0] word);
    logic [23:0] res;
    res            = word;
    res[VALID_BIT] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/hsst_stream_sched_if.sv
// Bundle between the burst scheduler, the per-source FIFO read ports and hssttop.
// master: scheduler side; slave: FIFOs + link side.
interface hsst_stream_sched_if #(
  parameter int N_SRC = 4,
  parameter int LVL_W = 13
);

  logic                     tx_ready;
  logic [N_SRC-1:0]         src_en;
  logic [N_SRC*LVL_W-1:0]   src_level;
  logic [N_SRC*24-1:0]      src_data;
  logic [N_SRC-1:0]         src_rd_en;
  logic [23:0]              tx_data;
  logic [2:0]               grant_id;
  logic                     busy;
  logic                     abort;

  modport master (
    input  tx_ready, src_en, src_level, src_data,
    output src_rd_en, tx_data, grant_id, busy, abort
  );

  modport slave (
    output tx_ready, src_en, src_level, src_data,
    input  src_rd_en, tx_data, grant_id, busy, abort
  );

endinterface

// File: rtl/hsst_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// from N_SRC-1 back to 0.
module hsst_rr_pick #(
  parameter int N_SRC = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [PTR_W-1:0] gnt_id,
  output logic             any
);

  localparam int               SUM_W = PTR_W + 1;
  localparam logic [N_SRC-1:0] ONE   = {{(N_SRC-1){1'b0}}, 1'b1};

  logic [SUM_W-1:0] sum_s;
  logic [PTR_W-1:0] idx_s;

  // Scan offsets from farthest to nearest so the requester closest to ptr is the last one kept.
  always_comb begin
    sum_s  = '0;
    idx_s  = '0;
    gnt_id = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      sum_s  = {1'b0, ptr} + SUM_W'(k);
      sum_s  = (sum_s >= SUM_W'(N_SRC)) ? (sum_s - SUM_W'(N_SRC)) : sum_s;
      idx_s  = sum_s[PTR_W-1:0];
      gnt_id = req[idx_s] ? idx_s : gnt_id;
    end
    any = |req;
    gnt = any ? (ONE << gnt_id) : '0;
  end

endmodule

// File: rtl/hsst_stream_sched.sv
// Round-robin burst scheduler sharing one HSST TX lane between N_SRC pixel FIFOs.
// Each burst: one header word (source id) then BURST_LEN data words read from the
// granted FIFO. A lost link aborts the burst and discards words in flight.
module hsst_stream_sched
  import hsst_sched_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int BURST_LEN = 64,
  parameter int LVL_W     = 13
) (
  input logic               clk,
  input logic               rstn,
  hsst_stream_sched_if.master bus
);

  localparam int               PTR_W    = $clog2(N_SRC);
  localparam int               CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] LVL_MIN  = LVL_W'(BURST_LEN);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_SRC - 1);

  sched_state_e     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] grant_r;
  logic [N_SRC-1:0] grant_oh_r;
  logic             rd_d1_r;
  logic             abort_r;
  logic             busy_r;
  logic [23:0]      tx_data_r;

  logic             rd_s;
  logic             abort_s;
  logic             load_s;
  logic [N_SRC-1:0] elig_s;
  logic [N_SRC-1:0] pick_gnt_s;
  logic [PTR_W-1:0] pick_id_s;
  logic             pick_any_s;
  logic [23:0]      src_word_s;

  // A source may be granted only when a whole burst is already sitting in its FIFO.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      elig_s[i] = bus.src_en[i] & (bus.src_level[i*LVL_W +: LVL_W] >= LVL_MIN);
    end
  end

  hsst_rr_pick #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (elig_s),
    .ptr    (rr_ptr_r),
    .gnt    (pick_gnt_s),
    .gnt_id (pick_id_s),
    .any    (pick_any_s)
  );

  // Read-data mux for the currently granted FIFO.
  always_comb begin
    src_word_s = IDLE_WORD;
    for (int i = 0; i < N_SRC; i++) begin
      src_word_s = (grant_r == PTR_W'(i)) ? bus.src_data[i*24 +: 24] : src_word_s;
    end
  end

  // FSM state and burst counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state, FIFO read strobe and abort decision; reads only happen while the link is up.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rd_s    = 1'b0;
    abort_s = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (bus.tx_ready && pick_any_s) begin
          load_s  = 1'b1;
          state_s = ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (!bus.tx_ready) begin
          abort_s = 1'b1;
          cnt_s   = '0;
          state_s = ST_IDLE;
        end else begin
          rd_s    = 1'b1;
          cnt_s   = CNT_W'(1);
          state_s = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!bus.tx_ready) begin
          abort_s = 1'b1;
          cnt_s   = '0;
          state_s = ST_IDLE;
        end else if (cnt_r < CNT_FULL) begin
          rd_s    = 1'b1;
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = (cnt_r == CNT_LAST) ? ST_GAP : ST_BURST;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_GAP: begin
        cnt_s   = '0;
        state_s = ST_IDLE;
        if (!bus.tx_ready) begin
          abort_s = 1'b1;
        end else begin
          abort_s = 1'b0;
        end
      end
      default: begin
        cnt_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping and the registered TX word; an abort wipes the word in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r   <= '0;
      grant_r    <= '0;
      grant_oh_r <= '0;
      rd_d1_r    <= 1'b0;
      abort_r    <= 1'b0;
      busy_r     <= 1'b0;
      tx_data_r  <= IDLE_WORD;
    end else begin
      rd_d1_r <= rd_s;
      abort_r <= abort_s;
      busy_r  <= (state_s != ST_IDLE);
      if (load_s) begin
        grant_r    <= pick_id_s;
        grant_oh_r <= pick_gnt_s;
        rr_ptr_r   <= (pick_id_s == PTR_MAX) ? '0 : (pick_id_s + PTR_W'(1));
      end else begin
        grant_r    <= grant_r;
        grant_oh_r <= grant_oh_r;
        rr_ptr_r   <= rr_ptr_r;
      end
      if (abort_s) begin
        tx_data_r <= IDLE_WORD;
      end else if (rd_d1_r) begin
        tx_data_r <= force_valid(src_word_s);
      end else if (state_r == ST_HDR) begin
        tx_data_r <= make_hdr(3'(grant_r));
      end else begin
        tx_data_r <= IDLE_WORD;
      end
    end
  end

  assign bus.src_rd_en = rd_s ? grant_oh_r : '0;
  assign bus.tx_data   = tx_data_r;
  assign bus.grant_id  = 3'(grant_r);
  assign bus.busy      = busy_r;
  assign bus.abort     = abort_r;

endmodule

// File: tb/tb_hsst_stream_sched.sv
// Directed bench for hsst_stream_sched with N_SRC=4, BURST_LEN=4, LVL_W=13.
// Simple FIFO models return a distinct word per source and read index.
module tb_hsst_stream_sched;

  localparam int N_SRC     = 4;
  localparam int BURST_LEN = 4;
  localparam int LVL_W     = 13;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [LVL_W-1:0] lvl    [N_SRC];
  logic [23:0]      fifo_q [N_SRC] = '{default: 24'h00_0000};
  logic [7:0]       seq    [N_SRC] = '{default: 8'd0};

  hsst_stream_sched_if #(.N_SRC(N_SRC), .LVL_W(LVL_W)) bus ();

  hsst_stream_sched #(
    .N_SRC     (N_SRC),
    .BURST_LEN (BURST_LEN),
    .LVL_W     (LVL_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign bus.src_level[g*LVL_W +: LVL_W] = lvl[g];
    assign bus.src_data[g*24 +: 24]        = fifo_q[g];
  end

  function automatic logic [23:0] mk_word(input int i, input logic [7:0] s);
    return {4'hA, 4'(i), s, 8'h15};
  endfunction

  function automatic logic [23:0] exp_word(input int i, input logic [7:0] s);
    return mk_word(i, s) | 24'h00_0080;
  endfunction

  function automatic logic [23:0] exp_hdr(input int i);
    return {8'hC3, 5'b0_0000, 3'(i), 8'hFF};
  endfunction

  // FIFO read ports: data appears the cycle after rd_en.
  always @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.src_rd_en[i]) begin
        fifo_q[i] <= mk_word(i, seq[i]);
        seq[i]    <= seq[i] + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_levels(input logic [LVL_W-1:0] v);
    for (int i = 0; i < N_SRC; i++) lvl[i] = v;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2;
    rstn = 1'b0;
    bus.tx_ready = 1'b1;
    bus.src_en   = 4'hF;
    set_levels(13'd8);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (bus.tx_data !== 24'h00_0000 || bus.src_rd_en !== 4'h0 || bus.busy !== 1'b0 ||
          bus.abort !== 1'b0 || bus.grant_id !== 3'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: tx_data=%h rd_en=%b busy=%b abort=%b grant=%0d, required all zero",
                 k, bus.tx_data, bus.src_rd_en, bus.busy, bus.abort, bus.grant_id);
      end
    end
    set_levels(13'd0);
    rstn = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [7:0]  s0;
    logic [3:0]  rd_exp;
    logic [23:0] tx_exp;
    logic        busy_exp;
    do_reset();
    bus.tx_ready = 1'b1;
    bus.src_en   = 4'hF;
    set_levels(13'd0);
    lvl[1] = 13'd4;
    s0 = seq[1];
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) lvl[1] = 13'd0;
      rd_exp   = (k <= 4) ? 4'b0010 : 4'b0000;
      busy_exp = (k <= 5);
      case (k)
        2:          tx_exp = 24'hC3_01FF;
        3, 4, 5, 6: tx_exp = exp_word(1, s0 + 8'(k - 3));
        default:    tx_exp = 24'h00_0000;
      endcase
      n_checks++;
      if (bus.src_rd_en !== rd_exp) begin
        n_fail++;
        $display("FAIL single_rd[%0d]: got %b want %b", k, bus.src_rd_en, rd_exp);
      end
      n_checks++;
      if (bus.tx_data !== tx_exp) begin
        n_fail++;
        $display("FAIL single_tx[%0d]: got %h want %h", k, bus.tx_data, tx_exp);
      end
      n_checks++;
      if (bus.busy !== busy_exp || bus.grant_id !== 3'd1) begin
        n_fail++;
        $display("FAIL single_busy[%0d]: busy=%b grant=%0d want busy=%b grant=1",
                 k, bus.busy, bus.grant_id, busy_exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] tx_tr [1:32];
    logic [7:0]  s0 [N_SRC];
    int          nb [N_SRC];
    int          hc [8];
    int          hid [8];
    int          nh;
    int          eid;
    int          idx;
    logic [23:0] w_exp;
    do_reset();
    bus.tx_ready = 1'b1;
    bus.src_en   = 4'hF;
    set_levels(13'd100);
    for (int i = 0; i < N_SRC; i++) begin
      s0[i] = seq[i];
      nb[i] = 0;
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      tx_tr[k] = bus.tx_data;
    end
    nh = 0;
    for (int k = 1; k <= 32; k++) begin
      if (tx_tr[k][23:16] == 8'hC3 && nh < 8) begin
        hc[nh]  = k;
        hid[nh] = int'(tx_tr[k][10:8]);
        nh++;
      end
    end
    n_checks++;
    if (nh < 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d headers want at least 5", nh);
    end
    for (int h = 0; h < 5 && h < nh; h++) begin
      eid = h % N_SRC;
      n_checks++;
      if (tx_tr[hc[h]] !== exp_hdr(eid)) begin
        n_fail++;
        $display("FAIL rr_hdr[%0d]: got %h (id %0d) want %h", h, tx_tr[hc[h]], hid[h], exp_hdr(eid));
      end
      for (int w = 0; w < BURST_LEN; w++) begin
        idx = hc[h] + 1 + w;
        if (idx <= 32) begin
          w_exp = exp_word(eid, s0[eid] + 8'(BURST_LEN * nb[eid] + w));
          n_checks++;
          if (tx_tr[idx] !== w_exp) begin
            n_fail++;
            $display("FAIL rr_data[%0d.%0d]: got %h want %h", h, w, tx_tr[idx], w_exp);
          end
        end
      end
      idx = hc[h] + BURST_LEN + 1;
      if (idx <= 32) begin
        n_checks++;
        if (tx_tr[idx] !== 24'h00_0000) begin
          n_fail++;
          $display("FAIL rr_gap[%0d]: got %h want 000000", h, tx_tr[idx]);
        end
      end
      nb[eid]++;
    end
  endtask

  task automatic test_threshold();
    do_reset();
    bus.tx_ready = 1'b1;
    bus.src_en   = 4'hF;
    set_levels(13'd0);
    lvl[2] = 13'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.src_rd_en !== 4'h0 || bus.tx_data !== 24'h00_0000) begin
        n_fail++;
        $display("FAIL thresh_hold[%0d]: busy=%b rd_en=%b tx=%h want idle",
                 k, bus.busy, bus.src_rd_en, bus.tx_data);
      end
    end
    lvl[2] = 13'd4;
    tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.src_rd_en !== 4'b0100) begin
      n_fail++;
      $display("FAIL thresh_grant: busy=%b rd_en=%b want 1 / 0100", bus.busy, bus.src_rd_en);
    end
    tick();
    n_checks++;
    if (bus.tx_data !== 24'hC3_02FF) begin
      n_fail++;
      $display("FAIL thresh_hdr: got %h want c302ff", bus.tx_data);
    end
    lvl[2] = 13'd0;
  endtask

  task automatic test_link_drop();
    do_reset();
    bus.tx_ready = 1'b1;
    bus.src_en   = 4'hF;
    set_levels(13'd100);
    tick();
    tick();
    n_checks++;
    if (bus.src_rd_en !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_pre: rd_en=%b want 0001", bus.src_rd_en);
    end
    bus.tx_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.src_rd_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_rd_same_cycle: rd_en=%b want 0000", bus.src_rd_en);
    end
    tick();
    n_checks++;
    if (bus.abort !== 1'b1 || bus.tx_data !== 24'h00_0000 || bus.busy !== 1'b0 || bus.src_rd_en !== 4'h0) begin
      n_fail++;
      $display("FAIL drop_abort: abort=%b tx=%h busy=%b rd_en=%b want 1/000000/0/0000",
               bus.abort, bus.tx_data, bus.busy, bus.src_rd_en);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.abort !== 1'b0 || bus.busy !== 1'b0 || bus.src_rd_en !== 4'h0 || bus.tx_data !== 24'h00_0000) begin
        n_fail++;
        $display("FAIL drop_idle[%0d]: abort=%b busy=%b rd_en=%b tx=%h want all zero",
                 k, bus.abort, bus.busy, bus.src_rd_en, bus.tx_data);
      end
    end
    bus.tx_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.src_rd_en !== 4'b0010 || bus.grant_id !== 3'd1) begin
      n_fail++;
      $display("FAIL drop_regrant: busy=%b rd_en=%b grant=%0d want 1/0010/1",
               bus.busy, bus.src_rd_en, bus.grant_id);
    end
    tick();
    n_checks++;
    if (bus.tx_data !== 24'hC3_01FF) begin
      n_fail++;
      $display("FAIL drop_hdr: got %h want c301ff", bus.tx_data);
    end
  endtask

  task automatic test_mask();
    logic [3:0] rd_or;
    int         hid [8];
    int         nh;
    int         eid;
    do_reset();
    bus.tx_ready = 1'b1;
    bus.src_en   = 4'b1010;
    set_levels(13'd100);
    rd_or = 4'h0;
    nh    = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      rd_or = rd_or | bus.src_rd_en;
      if (bus.tx_data[23:16] == 8'hC3 && nh < 8) begin
        hid[nh] = int'(bus.tx_data[10:8]);
        nh++;
      end
    end
    n_checks++;
    if (nh < 4) begin
      n_fail++;
      $display("FAIL mask_count: got %0d headers want at least 4", nh);
    end
    for (int h = 0; h < 4 && h < nh; h++) begin
      eid = (h % 2 == 0) ? 1 : 3;
      n_checks++;
      if (hid[h] != eid) begin
        n_fail++;
        $display("FAIL mask_order[%0d]: got id %0d want %0d", h, hid[h], eid);
      end
    end
    n_checks++;
    if (rd_or !== 4'b1010) begin
      n_fail++;
      $display("FAIL mask_rd_union: got %b want 1010", rd_or);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.tx_ready = 1'b1;
    bus.src_en   = 4'hF;
    set_levels(13'd0);
    lvl[3] = 13'd100;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 3'd3) begin
      n_fail++;
      $display("FAIL areset_pre: busy=%b grant=%0d want 1/3", bus.busy, bus.grant_id);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.tx_data !== 24'h00_0000 || bus.src_rd_en !== 4'h0 || bus.busy !== 1'b0 ||
        bus.abort !== 1'b0 || bus.grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_now: tx=%h rd_en=%b busy=%b abort=%b grant=%0d want all zero",
               bus.tx_data, bus.src_rd_en, bus.busy, bus.abort, bus.grant_id);
    end
    tick();
    n_checks++;
    if (bus.tx_data !== 24'h00_0000 || bus.busy !== 1'b0 || bus.src_rd_en !== 4'h0) begin
      n_fail++;
      $display("FAIL areset_hold: tx=%h busy=%b rd_en=%b want zero", bus.tx_data, bus.busy, bus.src_rd_en);
    end
    set_levels(13'd0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn         = 1'b1;
    bus.tx_ready = 1'b0;
    bus.src_en   = 4'h0;
    set_levels(13'd0);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_threshold();
    test_link_drop();
    test_mask();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
